// File: rtl/pulpino_boot_seq.sv
// Power-on / soft-reset sequencer for the PULPino core region.
// Holds peripheral and core resets until the FLL locks (or a timeout
// expires), releases the peripheral reset, then after a fixed hold time
// releases the core reset with a freshly latched boot address. A software
// core-only reset drains the core and re-runs the core reset phase.
module pulpino_boot_seq #(
    parameter int unsigned RST_HOLD_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT      = 1024,
    parameter int unsigned DRAIN_TIMEOUT     = 256,
    parameter logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        testmode_i,
    input  logic        fll_lock_i,
    input  logic        fetch_enable_i,
    input  logic        core_busy_i,
    input  logic        soft_rst_req_i,
    input  logic [31:0] boot_addr_i,
    output logic        rstn_periph_o,
    output logic        rstn_core_o,
    output logic        fetch_enable_o,
    output logic [31:0] boot_addr_o,
    output logic [2:0]  state_o,
    output logic        lock_timeout_o,
    output logic        lock_lost_o
);

    // Counter is sized for the largest of the three count limits plus one bit.
    localparam int unsigned MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_AB > DRAIN_TIMEOUT) ? MAX_AB : DRAIN_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    localparam logic [2:0] S_WAIT_LOCK  = 3'd0;
    localparam logic [2:0] S_PERIPH_REL = 3'd1;
    localparam logic [2:0] S_CORE_READY = 3'd2;
    localparam logic [2:0] S_RUN        = 3'd3;
    localparam logic [2:0] S_DRAIN      = 3'd4;
    localparam logic [2:0] S_CORE_RST   = 3'd5;

    logic             lock_meta;
    logic             lock_sync;
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_en;
    logic             lock_last;
    logic             hold_last;
    logic             drain_last;

    logic             rstn_periph_d;
    logic             rstn_core_d;
    logic             fetch_enable_d;
    logic [31:0]      boot_addr_d;
    logic             lock_timeout_d;
    logic             lock_lost_d;

    assign lock_last  = (cnt_q == LOCK_LAST);
    assign hold_last  = (cnt_q == HOLD_LAST);
    assign drain_last = (cnt_q == DRAIN_LAST);

    // Only the timed states advance the counter; CORE_READY/RUN leave it parked.
    assign cnt_en = (state_q == S_WAIT_LOCK)  || (state_q == S_PERIPH_REL) ||
                    (state_q == S_DRAIN)      || (state_q == S_CORE_RST);

    assign state_o = state_q;

    // Two-flop synchroniser for the asynchronous FLL lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= fll_lock_i;
            lock_sync <= lock_meta;
        end
    end

    // State register and phase counter; counter restarts on every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_LOCK: begin
                if (lock_sync || testmode_i || lock_last) begin
                    state_d = S_PERIPH_REL;
                end
            end
            S_PERIPH_REL: begin
                if (hold_last) begin
                    state_d = S_CORE_READY;
                end
            end
            S_CORE_READY: begin
                if (fetch_enable_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (soft_rst_req_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!core_busy_i || drain_last) begin
                    state_d = S_CORE_RST;
                end
            end
            S_CORE_RST: begin
                if (hold_last) begin
                    state_d = S_CORE_READY;
                end
            end
            default: begin
                state_d = S_WAIT_LOCK;
            end
        endcase
    end

    // Next values of the registered outputs, decided from the current state.
    always_comb begin
        rstn_periph_d  = rstn_periph_o;
        rstn_core_d    = rstn_core_o;
        fetch_enable_d = 1'b0;
        boot_addr_d    = boot_addr_o;
        lock_timeout_d = lock_timeout_o;
        // Lock loss is only meaningful once the lock wait is over and the
        // lock is actually being relied on (not bypassed by test mode).
        lock_lost_d    = lock_lost_o |
                         ((state_q != S_WAIT_LOCK) && !lock_sync && !testmode_i);
        case (state_q)
            S_WAIT_LOCK: begin
                rstn_core_d = 1'b0;
                if (lock_sync || testmode_i) begin
                    rstn_periph_d = 1'b1;
                end else if (lock_last) begin
                    rstn_periph_d  = 1'b1;
                    lock_timeout_d = 1'b1;
                end
            end
            S_PERIPH_REL: begin
                if (hold_last) begin
                    rstn_core_d = 1'b1;
                    boot_addr_d = boot_addr_i;
                end
            end
            S_CORE_READY: begin
                fetch_enable_d = fetch_enable_i;
            end
            S_RUN: begin
                // A soft reset request overrides the fetch-enable pass-through.
                fetch_enable_d = soft_rst_req_i ? 1'b0 : fetch_enable_i;
            end
            S_DRAIN: begin
                if (!core_busy_i || drain_last) begin
                    rstn_core_d = 1'b0;
                end
            end
            S_CORE_RST: begin
                if (hold_last) begin
                    rstn_core_d = 1'b1;
                    boot_addr_d = boot_addr_i;
                end
            end
            default: begin
                // Recovery from an illegal encoding: park the core in reset but
                // leave the peripheral reset alone, it only ever falls on rst_n.
                rstn_core_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstn_periph_o  <= 1'b0;
            rstn_core_o    <= 1'b0;
            fetch_enable_o <= 1'b0;
            boot_addr_o    <= BOOT_ADDR_DEFAULT;
            lock_timeout_o <= 1'b0;
            lock_lost_o    <= 1'b0;
        end else begin
            rstn_periph_o  <= rstn_periph_d;
            rstn_core_o    <= rstn_core_d;
            fetch_enable_o <= fetch_enable_d;
            boot_addr_o    <= boot_addr_d;
            lock_timeout_o <= lock_timeout_d;
            lock_lost_o    <= lock_lost_d;
        end
    end

endmodule

// File: tb/tb_pulpino_boot_seq.sv
// Scoreboard bench for pulpino_boot_seq: stimulus pushes each expected output
// change (with the clock edge it must appear on) into a queue; the monitor
// pops and compares whenever the DUT's output vector changes.
module tb_pulpino_boot_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        testmode_i;
    logic        fll_lock_i;
    logic        fetch_enable_i;
    logic        core_busy_i;
    logic        soft_rst_req_i;
    logic [31:0] boot_addr_i;
    logic        rstn_periph_o;
    logic        rstn_core_o;
    logic        fetch_enable_o;
    logic [31:0] boot_addr_o;
    logic [2:0]  state_o;
    logic        lock_timeout_o;
    logic        lock_lost_o;

    typedef struct {
        int          cyc;
        logic [39:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    pulpino_boot_seq #(
        .RST_HOLD_CYCLES  (16),
        .LOCK_TIMEOUT     (1024),
        .DRAIN_TIMEOUT    (256),
        .BOOT_ADDR_DEFAULT(32'h0000_8000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .testmode_i    (testmode_i),
        .fll_lock_i    (fll_lock_i),
        .fetch_enable_i(fetch_enable_i),
        .core_busy_i   (core_busy_i),
        .soft_rst_req_i(soft_rst_req_i),
        .boot_addr_i   (boot_addr_i),
        .rstn_periph_o (rstn_periph_o),
        .rstn_core_o   (rstn_core_o),
        .fetch_enable_o(fetch_enable_o),
        .boot_addr_o   (boot_addr_o),
        .state_o       (state_o),
        .lock_timeout_o(lock_timeout_o),
        .lock_lost_o   (lock_lost_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [39:0] snap();
        return {state_o, rstn_periph_o, rstn_core_o, fetch_enable_o,
                lock_timeout_o, lock_lost_o, boot_addr_o};
    endfunction

    function automatic string fmt(input logic [39:0] v);
        return $sformatf("st=%0d per=%b core=%b fe=%b lt=%b ll=%b ba=%h",
                         v[39:37], v[36], v[35], v[34], v[33], v[32], v[31:0]);
    endfunction

    // cyc < 0 means the edge number is not checked.
    task automatic expect_at(input int c, input string nm, input logic [2:0] st,
                             input logic per, input logic core, input logic fe,
                             input logic lt, input logic ll, input logic [31:0] ba);
        exp_t e;
        e.cyc  = c;
        e.val  = {st, per, core, fe, lt, ll, ba};
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Assert rst_n between edges; outputs must reach reset values with no edge.
    task automatic async_reset(input string nm);
        @(posedge clk);
        #2;
        expect_at(cyc, nm, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_8000);
        rst_n = 1'b0;
    endtask

    // Monitor: compare each observed output change against the queue head.
    initial begin
        logic [39:0] prev;
        logic [39:0] cur;
        exp_t        e;
        prev = 'x;
        @(negedge clk);
        forever begin
            #1;
            cur = snap();
            if (cur !== prev) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change: got %s at cycle %0d, required no change (prev %s)",
                             fmt(cur), cyc, fmt(prev));
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.val || (e.cyc >= 0 && e.cyc != cyc)) begin
                        $display("FAIL %s: got %s at cycle %0d, required %s at cycle %0d",
                                 e.name, fmt(cur), cyc, fmt(e.val), e.cyc);
                    end else begin
                        n_pass++;
                    end
                end
                prev = cur;
            end
            @(negedge clk or negedge rst_n);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by time %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int base;
        int c;
        testmode_i     = 1'b0;
        fll_lock_i     = 1'b1;
        fetch_enable_i = 1'b0;
        core_busy_i    = 1'b0;
        soft_rst_req_i = 1'b0;
        boot_addr_i    = 32'h0000_8000;
        expect_at(-1, "reset_state", 3'd0, 0, 0, 0, 0, 0, 32'h0000_8000);

        // Nominal boot with lock high.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        expect_at(base + 3,  "periph_release", 3'd1, 1, 0, 0, 0, 0, 32'h0000_8000);
        expect_at(base + 19, "core_release",   3'd2, 1, 1, 0, 0, 0, 32'h0000_8000);

        // Fetch gating.
        wait_cyc(base + 24);
        fetch_enable_i = 1'b1;
        expect_at(cyc + 1, "fetch_rise", 3'd3, 1, 1, 1, 0, 0, 32'h0000_8000);
        repeat (4) @(negedge clk);
        fetch_enable_i = 1'b0;
        expect_at(cyc + 1, "fetch_fall", 3'd3, 1, 1, 0, 0, 0, 32'h0000_8000);
        repeat (3) @(negedge clk);
        fetch_enable_i = 1'b1;
        expect_at(cyc + 1, "fetch_rise_again", 3'd3, 1, 1, 1, 0, 0, 32'h0000_8000);
        repeat (2) @(negedge clk);

        // Soft reset, core busy for 10 cycles, fetch_enable_i kept high.
        c = cyc;
        soft_rst_req_i = 1'b1;
        core_busy_i    = 1'b1;
        boot_addr_i    = 32'h0000_0080;
        expect_at(c + 1,  "drain_entry",    3'd4, 1, 1, 0, 0, 0, 32'h0000_8000);
        expect_at(c + 11, "core_rst_entry", 3'd5, 1, 0, 0, 0, 0, 32'h0000_8000);
        expect_at(c + 27, "core_rerelease", 3'd2, 1, 1, 0, 0, 0, 32'h0000_0080);
        expect_at(c + 28, "run_again",      3'd3, 1, 1, 1, 0, 0, 32'h0000_0080);
        @(negedge clk);
        soft_rst_req_i = 1'b0;
        wait_cyc(c + 10);
        core_busy_i = 1'b0;

        // Drain timeout with core_busy_i stuck high.
        wait_cyc(c + 30);
        c = cyc;
        soft_rst_req_i = 1'b1;
        core_busy_i    = 1'b1;
        fetch_enable_i = 1'b0;
        boot_addr_i    = 32'h1234_5600;
        expect_at(c + 1,   "drain_timeout_entry", 3'd4, 1, 1, 0, 0, 0, 32'h0000_0080);
        expect_at(c + 257, "drain_timeout_exit",  3'd5, 1, 0, 0, 0, 0, 32'h0000_0080);
        expect_at(c + 273, "core_rerelease_2",    3'd2, 1, 1, 0, 0, 0, 32'h1234_5600);
        @(negedge clk);
        soft_rst_req_i = 1'b0;
        wait_cyc(c + 280);
        core_busy_i = 1'b0;

        // Soft reset request outside RUN must not change anything.
        soft_rst_req_i = 1'b1;
        @(negedge clk);
        soft_rst_req_i = 1'b0;
        repeat (3) @(negedge clk);

        // Mid-sequence reset during PERIPH_REL count 7.
        async_reset("reset_from_core_ready");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        expect_at(base + 3, "periph_release_2", 3'd1, 1, 0, 0, 0, 0, 32'h0000_8000);
        wait_cyc(base + 9);
        async_reset("reset_mid_periph_rel");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        expect_at(base + 3,  "restart_periph", 3'd1, 1, 0, 0, 0, 0, 32'h0000_8000);
        expect_at(base + 19, "restart_core",   3'd2, 1, 1, 0, 0, 0, 32'h1234_5600);
        wait_cyc(base + 22);

        // Lock timeout with lock held low.
        fll_lock_i = 1'b0;
        async_reset("reset_before_timeout");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        expect_at(base + 1024, "lock_timeout",       3'd1, 1, 0, 0, 1, 0, 32'h0000_8000);
        expect_at(base + 1025, "lock_lost",          3'd1, 1, 0, 0, 1, 1, 32'h0000_8000);
        expect_at(base + 1040, "core_after_timeout", 3'd2, 1, 1, 0, 1, 1, 32'h1234_5600);
        wait_cyc(base + 1045);

        // Test mode skips the lock wait; reset clears the sticky flags.
        testmode_i = 1'b1;
        async_reset("reset_clears_sticky");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        expect_at(base + 1,  "testmode_periph", 3'd1, 1, 0, 0, 0, 0, 32'h0000_8000);
        expect_at(base + 17, "testmode_core",   3'd2, 1, 1, 0, 0, 0, 32'h1234_5600);
        wait_cyc(base + 25);

        // Leaving test mode with no lock flags lock loss, no state change.
        testmode_i = 1'b0;
        expect_at(cyc + 1, "lock_lost_core_ready", 3'd2, 1, 1, 0, 0, 1, 32'h1234_5600);

        // Let outstanding expectations drain, then flag any left over.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_total++;
            $display("FAIL %s: got no change by cycle %0d, required %s at cycle %0d",
                     e.name, cyc, fmt(e.val), e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
